logic_unit_arbiter: RTL and testbench

- Shares one 32-bit bitwise logic unit between two requesters: req0 is the execute stage, req1 is the bit-mask/immediate engine.
- Round-robin arbitration with a valid/ready handshake on each request port.
- The result is registered and returned on a per-requester response port that also uses valid/ready.
- Sits beside the ALU and sequences every logical-op use of the shared datapath.

---
 rtl/logic_unit_pkg.sv | 19 +
 rtl/logic_op_unit.sv | 38 +++
 rtl/logic_unit_arbiter.sv | 153 +++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic-unit arbiter: op encodings, FSM state
// encoding and the default datapath width.
package logic_unit_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Op select encodings seen on reqN_op
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_ANDN = 2'b11;  // a & ~b

  // IDLE: waiting to accept a request. RESP: result held for its owner.
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational 32-bit (WIDTH) bitwise logic unit: one gate of each kind per
// bit, then a per-vector select on op_i. No carries, no state.
module logic_op_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       op_i,
  output logic [WIDTH-1:0] result_o
);

  logic [WIDTH-1:0] and_v;
  logic [WIDTH-1:0] or_v;
  logic [WIDTH-1:0] xor_v;
  logic [WIDTH-1:0] andn_v;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign and_v[i]  = a_i[i] & b_i[i];
    assign or_v[i]   = a_i[i] | b_i[i];
    assign xor_v[i]  = a_i[i] ^ b_i[i];
    assign andn_v[i] = a_i[i] & ~b_i[i];
  end

  // Pick the gate output matching the requested op
  always_comb begin
    result_o = and_v;
    case (op_i)
      OP_AND:  result_o = and_v;
      OP_OR:   result_o = or_v;
      OP_XOR:  result_o = xor_v;
      OP_ANDN: result_o = andn_v;
      default: result_o = and_v;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit between req0 (execute
// stage) and req1 (bit-mask/immediate engine). Result is registered and
// returned on the owner's response port.
//
// Handshake: a transfer happens on a port in any cycle where its valid and
// ready are both high. reqN_ready is high only in IDLE for the granted
// requester (it may depend on both reqX_valid, never on rspX_ready);
// rspN_valid is high only in RESP for the owner. Result and owner stay
// stable while the owner holds rsp ready low.
//
// Optional build macro LOGIC_ARB_STATS_EN adds saturating per-requester
// grant counters grant_cnt0/grant_cnt1 (STAT_W bits each).
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
`ifdef LOGIC_ARB_STATS_EN
  ,
  parameter int STAT_W = 16
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
`ifdef LOGIC_ARB_STATS_EN
  output logic [STAT_W-1:0] grant_cnt0,
  output logic [STAT_W-1:0] grant_cnt1,
`endif
  output logic             busy
);

  state_e           state_q, state_d;
  logic             last_grant_q;
  logic             owner_q;
  logic [WIDTH-1:0] result_q;

  logic             grant_vld;
  logic             grant_idx;
  logic             owner_rsp_ready;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] op_result;

  // Grant: single requester wins outright; on a tie the one not granted last
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_vld = 1'b1;
        grant_idx = ~last_grant_q;
      end else if (req0_valid) begin
        grant_vld = 1'b1;
        grant_idx = 1'b0;
      end else if (req1_valid) begin
        grant_vld = 1'b1;
        grant_idx = 1'b1;
      end
    end
  end

  // Steer the granted requester's operands into the shared unit
  assign sel_op = grant_idx ? req1_op : req0_op;
  assign sel_a  = grant_idx ? req1_a  : req0_a;
  assign sel_b  = grant_idx ? req1_b  : req0_b;

  logic_op_unit #(.WIDTH(WIDTH)) u_op (
    .a_i      (sel_a),
    .b_i      (sel_b),
    .op_i     (sel_op),
    .result_o (op_result)
  );

  assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: accept moves to RESP, owner's rsp ready returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = RESP;
      RESP:    if (owner_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: ready only for the granted port in IDLE, valid only for the owner in RESP
  always_comb begin
    req0_ready  = grant_vld && !grant_idx;
    req1_ready  = grant_vld && grant_idx;
    rsp0_valid  = (state_q == RESP) && !owner_q;
    rsp1_valid  = (state_q == RESP) && owner_q;
    busy        = (state_q == RESP);
    rsp0_result = result_q;
    rsp1_result = result_q;
  end

  // Capture result, owner and round-robin pointer on accept; hold otherwise
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_q     <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (grant_vld) begin
      result_q     <= op_result;
      owner_q      <= grant_idx;
      last_grant_q <= grant_idx;
    end
  end

`ifdef LOGIC_ARB_STATS_EN
  logic [STAT_W-1:0] grant_cnt0_q;
  logic [STAT_W-1:0] grant_cnt1_q;

  // Saturating accept counters, one per requester
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else if (grant_vld) begin
      if (!grant_idx && (grant_cnt0_q != {STAT_W{1'b1}}))
        grant_cnt0_q <= grant_cnt0_q + STAT_W'(1);
      if (grant_idx && (grant_cnt1_q != {STAT_W{1'b1}}))
        grant_cnt1_q <= grant_cnt1_q + STAT_W'(1);
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter. Build with LOGIC_ARB_STATS_EN
// defined to also exercise the grant counters.
module tb_logic_unit_arbiter;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [1:0]   req0_op = '0, req1_op = '0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [W-1:0] rsp0_result, rsp1_result;
  logic         busy;
`ifdef LOGIC_ARB_STATS_EN
  logic [15:0]  grant_cnt0, grant_cnt1;
`endif

  logic_unit_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_op     (req0_op),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_result (rsp0_result),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_op     (req1_op),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_result (rsp1_result),
`ifdef LOGIC_ARB_STATS_EN
    .grant_cnt0  (grant_cnt0),
    .grant_cnt1  (grant_cnt1),
`endif
    .busy        (busy)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return a & ~b;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  // Entry = {owner, result}; pushed on accept, popped on response handshake.
  logic [W:0] exp_q[$];
  logic [W:0] sb_e;

  always @(negedge clock) begin
    if (!reset) begin
      if (req0_valid && req0_ready) exp_q.push_back({1'b0, model(req0_op, req0_a, req0_b)});
      if (req1_valid && req1_ready) exp_q.push_back({1'b1, model(req1_op, req1_a, req1_b)});
      if (rsp0_valid && rsp0_ready) begin
        if (exp_q.size() == 0) check("sb_rsp0_unexpected", 1, 0);
        else begin
          sb_e = exp_q.pop_front();
          check("sb_rsp0", {1'b0, rsp0_result}, sb_e);
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        if (exp_q.size() == 0) check("sb_rsp1_unexpected", 1, 0);
        else begin
          sb_e = exp_q.pop_front();
          check("sb_rsp1", {1'b1, rsp1_result}, sb_e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One transaction on a port whose rsp ready is already high; checks the
  // result against a bench-supplied constant the cycle after accept.
  task automatic run_req(input bit port, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp, input string tag);
    int n;
    tick();
    if (port) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    n = 0;
    sample();
    while (!(port ? req1_ready : req0_ready) && n < 20) begin
      tick();
      sample();
      n++;
    end
    if (n >= 20) check({tag, "_accept_timeout"}, 0, 1);
    tick();
    if (port) req1_valid = 1'b0;
    else      req0_valid = 1'b0;
    sample();
    check({tag, "_valid"}, port ? rsp1_valid : rsp0_valid, 1);
    check({tag, "_result"}, port ? rsp1_result : rsp0_result, exp);
    tick();
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] expv;
  logic [1:0]   rop;
  logic [W-1:0] ra, rb;
  bit           acc0, acc1;

  initial begin
    // reset state
    sample();
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", rsp0_result, 0);
    check("rst_req0_ready", req0_ready, 0);
    tick();
    reset = 1'b0;

    // first AND on req0
    tick();
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'hF0F0_F0F0; req0_b = 32'hFF00_FF00;
    sample();
    check("t1_req0_ready", req0_ready, 1);
    check("t1_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    sample();
    check("t1_rsp0_valid", rsp0_valid, 1);
    check("t1_rsp0_result", rsp0_result, 32'hF000_F000);
    check("t1_rsp1_valid", rsp1_valid, 0);
    check("t1_busy", busy, 1);
    tick();
    rsp0_ready = 1'b1;
    sample();
    tick();
    sample();
    check("t1_drain_valid", rsp0_valid, 0);
    check("t1_drain_busy", busy, 0);

    // round robin with both valid continuously
    do_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    tick();
    req0_valid = 1'b1; req0_op = 2'($urandom_range(0, 3)); req0_a = $urandom(); req0_b = $urandom();
    req1_valid = 1'b1; req1_op = 2'($urandom_range(0, 3)); req1_a = $urandom(); req1_b = $urandom();
    for (int k = 0; k < 8; k++) begin
      sample();
      check($sformatf("rr_ready0_%0d", k), req0_ready, (k % 4) == 0);
      check($sformatf("rr_ready1_%0d", k), req1_ready, (k % 4) == 2);
      acc0 = req0_ready;
      acc1 = req1_ready;
      tick();
      if (acc0) begin
        req0_op = 2'($urandom_range(0, 3)); req0_a = $urandom(); req0_b = $urandom();
      end
      if (acc1) begin
        req1_op = 2'($urandom_range(0, 3)); req1_a = $urandom(); req1_b = $urandom();
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // backpressure on req1's response
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    tick();
    rop = 2'($urandom_range(0, 3)); ra = $urandom(); rb = $urandom();
    req1_valid = 1'b1; req1_op = rop; req1_a = ra; req1_b = rb;
    expv = model(rop, ra, rb);
    sample();
    check("bp_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b01; req0_a = $urandom(); req0_b = $urandom();
    for (int i = 0; i < 5; i++) begin
      sample();
      check($sformatf("bp_rsp1_valid_%0d", i), rsp1_valid, 1);
      check($sformatf("bp_rsp1_result_%0d", i), rsp1_result, expv);
      check($sformatf("bp_busy_%0d", i), busy, 1);
      check($sformatf("bp_req0_ready_%0d", i), req0_ready, 0);
      check($sformatf("bp_rsp0_valid_%0d", i), rsp0_valid, 0);
      tick();
    end
    rsp1_ready = 1'b1;
    sample();
    check("bp_drain_valid", rsp1_valid, 1);
    tick();
    rsp1_ready = 1'b0;
    sample();
    check("bp_after_busy", busy, 0);
    check("bp_after_rsp1_valid", rsp1_valid, 0);
    check("bp_after_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    rsp0_ready = 1'b1;
    tick();
    tick();

    // op sweep
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    run_req(1'b0, 2'b00, 32'h1234_5678, 32'h0F0F_F0F0, 32'h0204_5070, "op_and");
    run_req(1'b0, 2'b01, 32'h1234_5678, 32'h0F0F_F0F0, 32'h1F3F_F6F8, "op_or");
    run_req(1'b0, 2'b10, 32'h1234_5678, 32'h0F0F_F0F0, 32'h1D3B_A688, "op_xor");
    run_req(1'b0, 2'b11, 32'h1234_5678, 32'h0F0F_F0F0, 32'h1030_0608, "op_andn");
    run_req(1'b1, 2'b11, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, "op_andn_p1");
    run_req(1'b1, 2'b10, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, "op_xor_p1");

    // asynchronous reset while in RESP
    rsp0_ready = 1'b0;
    tick();
    req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'h0000_00FF; req0_b = 32'h0000_FF00;
    sample();
    tick();
    req0_valid = 1'b0;
    sample();
    check("ar_rsp0_valid_before", rsp0_valid, 1);
    #1 reset = 1'b1;
    exp_q.delete();
    #1;
    check("ar_rsp0_valid_async", rsp0_valid, 0);
    check("ar_busy_async", busy, 0);
    check("ar_result_async", rsp0_result, 0);
    tick();
    tick();
    reset = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 2'($urandom_range(0, 3)); req0_a = $urandom(); req0_b = $urandom();
    req1_valid = 1'b1; req1_op = 2'($urandom_range(0, 3)); req1_a = $urandom(); req1_b = $urandom();
    sample();
    check("ar_tie_req0_ready", req0_ready, 1);
    check("ar_tie_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    sample();
    tick();
    sample();
    check("ar_next_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    tick();
    tick();

`ifdef LOGIC_ARB_STATS_EN
    // grant counters
    do_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    check("st_rst_cnt0", grant_cnt0, 0);
    check("st_rst_cnt1", grant_cnt1, 0);
    for (int i = 0; i < 3; i++) begin
      rop = 2'($urandom_range(0, 3)); ra = $urandom(); rb = $urandom();
      run_req(1'b0, rop, ra, rb, model(rop, ra, rb), $sformatf("st_p0_%0d", i));
    end
    for (int i = 0; i < 2; i++) begin
      rop = 2'($urandom_range(0, 3)); ra = $urandom(); rb = $urandom();
      run_req(1'b1, rop, ra, rb, model(rop, ra, rb), $sformatf("st_p1_%0d", i));
    end
    sample();
    check("st_cnt0", grant_cnt0, 3);
    check("st_cnt1", grant_cnt1, 2);
    tick();
    force dut.grant_cnt0_q = 16'hFFFE;
    #1;
    release dut.grant_cnt0_q;
    for (int i = 0; i < 3; i++) begin
      rop = 2'($urandom_range(0, 3)); ra = $urandom(); rb = $urandom();
      run_req(1'b0, rop, ra, rb, model(rop, ra, rb), $sformatf("st_sat_%0d", i));
    end
    sample();
    check("st_cnt0_sat", grant_cnt0, 16'hFFFF);
    check("st_cnt1_hold", grant_cnt1, 2);
`endif

    // final report
    repeat (3) tick();
    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
